// File: rtl/ps2_key_if.sv
// Byte-stream input and decoded-key FIFO output of ps2_key_decoder.
// master drives bytes and consumes keys; slave is the decoder.
interface ps2_key_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [3:0]    key_data;
   logic          key_valid;
   logic          key_ready;
   logic [CW-1:0] count;
   logic          overflow;
   logic          ovf_clr;

   modport master (
      output rx_data, rx_valid, key_ready, ovf_clr,
      input  key_data, key_valid, count, overflow
   );

   modport slave (
      input  rx_data, rx_valid, key_ready, ovf_clr,
      output key_data, key_valid, count, overflow
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, maps digit keys to 0..9 and queues them.
// Define PS2_KEY_DECODER_HEX_EN to also decode the letter keys A..F as 10..15.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | waiting for a make code or a prefix
// ST_EXT     | E0 seen; next byte is an extended code
// ST_BRK     | F0 seen; next byte is a break code
// ST_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_key_decoder #(
   parameter int DEPTH        = 4,
   parameter int EMIT_ON_MAKE = 0
) (
   input logic      clk,
   input logic      rst_n,
   ps2_key_if.slave bus
);
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;
   localparam bit ON_MAKE = (EMIT_ON_MAKE != 0);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } state_t;

   state_t        state_q;
   logic [3:0]    held_q;
   logic          held_vld_q;
   logic [3:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q;

   logic          is_digit;
   logic [3:0]    digit;
   logic          push;
   logic          pop;
   logic          full;
   logic          push_ok;

   always_comb begin
      is_digit = 1'b1;
      digit    = 4'd0;
      case (bus.rx_data)
         8'h45, 8'h70: digit = 4'd0;
         8'h16, 8'h69: digit = 4'd1;
         8'h1E, 8'h72: digit = 4'd2;
         8'h26, 8'h7A: digit = 4'd3;
         8'h25, 8'h6B: digit = 4'd4;
         8'h2E, 8'h73: digit = 4'd5;
         8'h36, 8'h74: digit = 4'd6;
         8'h3D, 8'h6C: digit = 4'd7;
         8'h3E, 8'h75: digit = 4'd8;
         8'h46, 8'h7D: digit = 4'd9;
`ifdef PS2_KEY_DECODER_HEX_EN
         8'h1C:        digit = 4'd10;
         8'h32:        digit = 4'd11;
         8'h21:        digit = 4'd12;
         8'h23:        digit = 4'd13;
         8'h24:        digit = 4'd14;
         8'h2B:        digit = 4'd15;
`endif
         default:      is_digit = 1'b0;
      endcase
   end

   // A make repeats while the key is held; only a change of key or a re-press counts.
   always_comb begin
      push = 1'b0;
      if (bus.rx_valid && is_digit) begin
         if (state_q == ST_IDLE && ON_MAKE && !(held_vld_q && held_q == digit))
            push = 1'b1;
         if (state_q == ST_BRK && !ON_MAKE)
            push = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         held_q     <= 4'd0;
         held_vld_q <= 1'b0;
      end else if (bus.rx_valid) begin
         if (bus.rx_data == CODE_EXT) begin
            state_q <= ST_EXT;
         end else if (bus.rx_data == CODE_BRK) begin
            state_q <= (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (is_digit) begin
                     held_q     <= digit;
                     held_vld_q <= 1'b1;
                  end else begin
                     held_vld_q <= 1'b0;
                  end
               end
               ST_BRK: begin
                  if (is_digit)
                     held_vld_q <= 1'b0;
               end
               default: ;
            endcase
            state_q <= ST_IDLE;
         end
      end
   end

   assign full    = (count_q == CW'(DEPTH));
   assign pop     = (count_q != '0) && bus.key_ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= 4'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= digit;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
         // A drop in the same cycle as a clear must still be reported.
         if (push && full && !pop)
            ovf_q <= 1'b1;
         else if (bus.ovf_clr)
            ovf_q <= 1'b0;
      end
   end

   assign bus.key_data  = mem_q[rd_ptr_q];
   assign bus.key_valid = (count_q != '0);
   assign bus.count     = count_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a release-mode and a make-mode instance share one byte stream.
module tb_ps2_key_decoder;
   localparam int DEPTH = 4;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       rx_valid = 1'b0;
   logic       ready0   = 1'b0;
   logic       ready1   = 1'b0;
   logic       clr0     = 1'b0;
   logic       clr1     = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   ps2_key_if #(.DEPTH(DEPTH)) bus0 ();
   ps2_key_if #(.DEPTH(DEPTH)) bus1 ();

   assign bus0.rx_data   = rx_data;
   assign bus0.rx_valid  = rx_valid;
   assign bus0.key_ready = ready0;
   assign bus0.ovf_clr   = clr0;
   assign bus1.rx_data   = rx_data;
   assign bus1.rx_valid  = rx_valid;
   assign bus1.key_ready = ready1;
   assign bus1.ovf_clr   = clr1;

   ps2_key_decoder #(.DEPTH(DEPTH), .EMIT_ON_MAKE(0)) u_brk (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   ps2_key_decoder #(.DEPTH(DEPTH), .EMIT_ON_MAKE(1)) u_make (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_key(input logic [7:0] code);
      send(code);
      send(8'hF0);
      send(code);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pop(input int which, input logic [3:0] exp_v);
      if (which == 0) begin
         chk("pop0_valid", bus0.key_valid, 1);
         chk("pop0_data", bus0.key_data, exp_v);
         ready0 = 1'b1;
      end else begin
         chk("pop1_valid", bus1.key_valid, 1);
         chk("pop1_data", bus1.key_data, exp_v);
         ready1 = 1'b1;
      end
      @(negedge clk);
      ready0 = 1'b0;
      ready1 = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_count", bus0.count, 0);
      chk("rst_valid", bus0.key_valid, 0);
      chk("rst_data", bus0.key_data, 0);
      chk("rst_ovf", bus0.overflow, 0);
      chk("rst_valid_make", bus1.key_valid, 0);

      // release of top-row 1
      send(8'h16);
      chk("brk_no_key_on_make", bus0.key_valid, 0);
      send(8'hF0);
      send(8'h16);
      chk("brk1_valid", bus0.key_valid, 1);
      chk("brk1_data", bus0.key_data, 1);
      chk("brk1_count", bus0.count, 1);
      chk("make1_count", bus1.count, 1);
      pop(0, 4'd1);
      chk("brk1_drained_count", bus0.count, 0);
      chk("brk1_drained_valid", bus0.key_valid, 0);

      // typematic suppression
      do_reset();
      send(8'h1E);
      send(8'h1E);
      send(8'h1E);
      send(8'hF0);
      send(8'h1E);
      send(8'h1E);
      chk("typematic_count", bus1.count, 2);
      chk("typematic_brk_count", bus0.count, 1);
      pop(1, 4'd2);
      pop(1, 4'd2);
      chk("typematic_empty", bus1.key_valid, 0);

      // extended codes discarded, keypad decoded
      do_reset();
      send(8'hE0);
      send(8'h70);
      send(8'hE0);
      send(8'hF0);
      send(8'h70);
      chk("ext_discard", bus0.count, 0);
      chk("ext_discard_make", bus1.count, 0);
      send_key(8'h72);
      chk("kp_count", bus0.count, 1);
      chk("kp_make_count", bus1.count, 1);
      pop(0, 4'd2);
      chk("kp_empty", bus0.key_valid, 0);

      // overflow on the fifth release
      do_reset();
      send_key(8'h45);
      send_key(8'h16);
      send_key(8'h1E);
      send_key(8'h26);
      chk("full_no_ovf", bus0.overflow, 0);
      send_key(8'h25);
      chk("ovf_count", bus0.count, 4);
      chk("ovf_set", bus0.overflow, 1);
      pop(0, 4'd0);
      pop(0, 4'd1);
      pop(0, 4'd2);
      pop(0, 4'd3);
      chk("ovf_drained", bus0.key_valid, 0);
      chk("ovf_sticky", bus0.overflow, 1);
      @(negedge clk);
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      chk("ovf_clr", bus0.overflow, 0);

      // push and pop together while full
      do_reset();
      send_key(8'h2E);
      send_key(8'h36);
      send_key(8'h3D);
      send_key(8'h3E);
      chk("pp_full", bus0.count, 4);
      send(8'h46);
      send(8'hF0);
      @(negedge clk);
      rx_data  = 8'h46;
      rx_valid = 1'b1;
      ready0   = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      ready0   = 1'b0;
      chk("pp_count", bus0.count, 4);
      chk("pp_ovf", bus0.overflow, 0);
      pop(0, 4'd6);
      pop(0, 4'd7);
      pop(0, 4'd8);
      pop(0, 4'd9);
      chk("pp_empty", bus0.key_valid, 0);

      // reset in the middle of a break sequence
      do_reset();
      send(8'hF0);
      do_reset();
      send(8'h45);
      chk("midrst_no_key", bus0.count, 0);
      send(8'hF0);
      send(8'h45);
      chk("midrst_idle_count", bus0.count, 1);
      chk("midrst_idle_data", bus0.key_data, 0);

      // non-digit make clears the held key
      do_reset();
      send(8'h1E);
      send(8'h5A);
      send(8'h1E);
      chk("nondigit_rearm", bus1.count, 2);
      chk("nondigit_brk", bus0.count, 0);

      // letter keys
      do_reset();
      send_key(8'h1C);
`ifdef PS2_KEY_DECODER_HEX_EN
      chk("hex_count", bus0.count, 1);
      chk("hex_data", bus0.key_data, 10);
      chk("hex_make_count", bus1.count, 1);
`else
      chk("hex_off_count", bus0.count, 0);
      chk("hex_off_make_count", bus1.count, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
